// File: rtl/sdram_sched_pkg.sv
// rtl/sdram_sched_pkg.sv - shared encodings for the SDRAM line scheduler
//
// Purpose: command op encodings, scheduler FSM state encodings, frame-bank
// count, and the helper that picks the free bank of the triple buffer.
// Ports: none (package).

package sdram_sched_pkg;

    // Line-level command ops presented to the SDRAM command engine
    localparam logic [1:0] CMD_NOP     = 2'd0;
    localparam logic [1:0] CMD_WRITE   = 2'd1;
    localparam logic [1:0] CMD_READ    = 2'd2;
    localparam logic [1:0] CMD_REFRESH = 2'd3;

    // Scheduler FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Frame banks in rotation (0..NUM_FB-1); bank 3 is never used
    localparam int NUM_FB = 3;

    // The banks 0..NUM_FB-1 sum to a constant, so the one bank that is
    // neither a nor b is that sum minus both (a and b must differ).
    function automatic logic [1:0] free_bank(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] sum_all;
        sum_all = 2'(NUM_FB * (NUM_FB - 1) / 2);
        return sum_all - a - b;
    endfunction

endpackage

// File: rtl/fb_bank_rotator.sv
// rtl/fb_bank_rotator.sv - triple-buffer frame bank rotation
//
// Purpose: holds the capture bank (W), display bank (R), last completed
// capture bank (L) and the fresh flag, and rotates them on frame ends so
// that capture and display never share a bank.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   wr_frame_end   - 1-cycle pulse, capture frame finished
//   rd_frame_end   - 1-cycle pulse, display frame finished
//   wr_bank        - current capture bank (W)
//   rd_bank        - current display bank (R)

module fb_bank_rotator
    import sdram_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_frame_end,
    input  logic       rd_frame_end,
    output logic [1:0] wr_bank,
    output logic [1:0] rd_bank
);

    logic [1:0] w_q;
    logic [1:0] r_q;
    logic [1:0] l_q;
    logic       fresh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q     <= 2'd0;
            r_q     <= 2'd1;
            l_q     <= 2'd1;
            fresh_q <= 1'b0;
        end else if (wr_frame_end) begin
            // Capture moves into the bank display is not using and that it
            // did not just fill; the just-filled bank becomes L.
            l_q <= w_q;
            w_q <= free_bank(w_q, r_q);
            if (rd_frame_end) begin
                // Read rule applied after the write rule: display takes the
                // bank that was completed in this same cycle.
                r_q     <= w_q;
                fresh_q <= 1'b0;
            end else begin
                fresh_q <= 1'b1;
            end
        end else if (rd_frame_end && fresh_q) begin
            r_q     <= l_q;
            fresh_q <= 1'b0;
        end
    end

    assign wr_bank = w_q;
    assign rd_bank = r_q;

endmodule

// File: rtl/sdram_line_sched.sv
// rtl/sdram_line_sched.sv - SDRAM line traffic scheduler (write/read/refresh)
//
// Purpose: arbitrates capture line writes, display line reads and periodic
// auto-refresh, issuing one line-level command at a time to the SDRAM
// command engine with a valid/ready/done handshake, and owns frame bank
// rotation for the triple buffer.
// Ports:
//   i_clk, i_reset_n            - SDRAM clock, asynchronous active-low reset
//   i_wr_line_req/i_wr_line     - capture line request (level) and index
//   o_wr_line_ack               - pulse: write line completed
//   i_rd_line_req/i_rd_line     - display line request (level) and index
//   o_rd_line_ack               - pulse: read line completed
//   i_wr_frame_end/i_rd_frame_end - frame-end pulses driving bank rotation
//   o_cmd_valid/op/line/bank    - command offered to the SDRAM engine
//   i_cmd_ready                 - engine accepts the offered command
//   i_cmd_done                  - pulse: engine finished the command
//   o_wr_bank/o_rd_bank         - registered capture/display banks
//   o_ref_overrun               - sticky pending-refresh saturation flag
//   o_busy                      - FSM not in IDLE

module sdram_line_sched
    import sdram_sched_pkg::*;
#(
    parameter int REFI_CYCLES  = 889,
    parameter int REF_POSTPONE = 4,
    parameter int LINE_W       = 9
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr_line_req,
    input  logic [LINE_W-1:0] i_wr_line,
    output logic              o_wr_line_ack,
    input  logic              i_rd_line_req,
    input  logic [LINE_W-1:0] i_rd_line,
    output logic              o_rd_line_ack,
    input  logic              i_wr_frame_end,
    input  logic              i_rd_frame_end,
    output logic              o_cmd_valid,
    output logic [1:0]        o_cmd_op,
    output logic [LINE_W-1:0] o_cmd_line,
    output logic [1:0]        o_cmd_bank,
    input  logic              i_cmd_ready,
    input  logic              i_cmd_done,
    output logic [1:0]        o_wr_bank,
    output logic [1:0]        o_rd_bank,
    output logic              o_ref_overrun,
    output logic              o_busy
);

    localparam int CNT_W = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;

    logic [1:0]        state;
    logic [1:0]        op_q;
    logic [LINE_W-1:0] line_q;
    logic [1:0]        bank_q;

    logic [1:0]        w_bank;
    logic [1:0]        r_bank;

    logic [CNT_W-1:0]  ref_cnt;
    logic              ref_wrap;
    logic              ref_taken;
    logic              ref_urgent;
    logic [2:0]        pend;
    logic              overrun_q;

    logic              grant;
    logic [1:0]        grant_op;
    logic [LINE_W-1:0] grant_line;
    logic [1:0]        grant_bank;

    fb_bank_rotator u_rot (
        .clk          (i_clk),
        .rst_n        (i_reset_n),
        .wr_frame_end (i_wr_frame_end),
        .rd_frame_end (i_rd_frame_end),
        .wr_bank      (w_bank),
        .rd_bank      (r_bank)
    );

    // ---------------- refresh timer ----------------
    assign ref_wrap   = (ref_cnt == CNT_W'(REFI_CYCLES - 1));
    assign ref_taken  = o_cmd_valid && i_cmd_ready && (op_q == CMD_REFRESH);
    assign ref_urgent = (pend >= 3'(REF_POSTPONE));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ref_cnt   <= '0;
            pend      <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            // A tick and a refresh acceptance in the same cycle cancel out.
            case ({ref_wrap, ref_taken})
                2'b10: begin
                    if (pend == 3'd7) overrun_q <= 1'b1;
                    else              pend      <= pend + 3'd1;
                end
                2'b01: begin
                    if (pend != 3'd0) pend <= pend - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- fixed-priority arbiter ----------------
    always_comb begin
        grant      = 1'b0;
        grant_op   = CMD_NOP;
        grant_line = '0;
        grant_bank = 2'd0;
        if (ref_urgent) begin
            grant    = 1'b1;
            grant_op = CMD_REFRESH;
        end else if (i_rd_line_req) begin
            grant      = 1'b1;
            grant_op   = CMD_READ;
            grant_line = i_rd_line;
            grant_bank = r_bank;
        end else if (i_wr_line_req) begin
            grant      = 1'b1;
            grant_op   = CMD_WRITE;
            grant_line = i_wr_line;
            grant_bank = w_bank;
        end else if (pend != 3'd0) begin
            grant    = 1'b1;
            grant_op = CMD_REFRESH;
        end
    end

    // ---------------- command FSM ----------------
    // op/line/bank are latched at grant so a frame-end rotation during an
    // in-flight command cannot change the bank the engine is working on.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= ST_IDLE;
            op_q   <= CMD_NOP;
            line_q <= '0;
            bank_q <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        op_q   <= grant_op;
                        line_q <= grant_line;
                        bank_q <= grant_bank;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_cmd_ready) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_cmd_done) state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- registered bank copies ----------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wr_bank <= 2'd0;
            o_rd_bank <= 2'd1;
        end else begin
            o_wr_bank <= w_bank;
            o_rd_bank <= r_bank;
        end
    end

    // Command fields read as zero whenever nothing is offered.
    assign o_cmd_valid   = (state == ST_ISSUE);
    assign o_cmd_op      = o_cmd_valid ? op_q   : CMD_NOP;
    assign o_cmd_line    = o_cmd_valid ? line_q : '0;
    assign o_cmd_bank    = o_cmd_valid ? bank_q : 2'd0;
    assign o_rd_line_ack = (state == ST_DONE) && (op_q == CMD_READ);
    assign o_wr_line_ack = (state == ST_DONE) && (op_q == CMD_WRITE);
    assign o_ref_overrun = overrun_q;
    assign o_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_sdram_line_sched.sv
// tb/tb_sdram_line_sched.sv - directed self-checking bench for sdram_line_sched

module tb_sdram_line_sched;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_wr_line_req;
    logic [8:0] i_wr_line;
    logic       o_wr_line_ack;
    logic       i_rd_line_req;
    logic [8:0] i_rd_line;
    logic       o_rd_line_ack;
    logic       i_wr_frame_end;
    logic       i_rd_frame_end;
    logic       o_cmd_valid;
    logic [1:0] o_cmd_op;
    logic [8:0] o_cmd_line;
    logic [1:0] o_cmd_bank;
    logic       i_cmd_ready;
    logic       i_cmd_done;
    logic [1:0] o_wr_bank;
    logic [1:0] o_rd_bank;
    logic       o_ref_overrun;
    logic       o_busy;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    sdram_line_sched #(
        .REFI_CYCLES  (16),
        .REF_POSTPONE (4),
        .LINE_W       (9)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_wr_line_req  (i_wr_line_req),
        .i_wr_line      (i_wr_line),
        .o_wr_line_ack  (o_wr_line_ack),
        .i_rd_line_req  (i_rd_line_req),
        .i_rd_line      (i_rd_line),
        .o_rd_line_ack  (o_rd_line_ack),
        .i_wr_frame_end (i_wr_frame_end),
        .i_rd_frame_end (i_rd_frame_end),
        .o_cmd_valid    (o_cmd_valid),
        .o_cmd_op       (o_cmd_op),
        .o_cmd_line     (o_cmd_line),
        .o_cmd_bank     (o_cmd_bank),
        .i_cmd_ready    (i_cmd_ready),
        .i_cmd_done     (i_cmd_done),
        .o_wr_bank      (o_wr_bank),
        .o_rd_bank      (o_rd_bank),
        .o_ref_overrun  (o_ref_overrun),
        .o_busy         (o_busy)
    );

    // Engine model: accept the offered command at once, finish it one cycle
    // later. Called at a negedge; returns at the negedge after DONE.
    task automatic serve(input bit hold_req, output logic [1:0] op, output logic [8:0] ln,
                         output logic [1:0] bk, output logic ra, output logic wa, output logic ok);
        ok = 1'b0; op = 2'd0; ln = 9'd0; bk = 2'd0; ra = 1'b0; wa = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (o_cmd_valid) begin ok = 1'b1; break; end
            @(negedge i_clk);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL serve_timeout: no command offered within 400 cycles");
            return;
        end
        op = o_cmd_op; ln = o_cmd_line; bk = o_cmd_bank;
        i_cmd_ready = 1'b1;
        @(negedge i_clk);
        i_cmd_ready = 1'b0;
        i_cmd_done  = 1'b1;
        @(negedge i_clk);
        i_cmd_done = 1'b0;
        ra = o_rd_line_ack;
        wa = o_wr_line_ack;
        if (!hold_req) begin
            if (ra) i_rd_line_req = 1'b0;
            if (wa) i_wr_line_req = 1'b0;
        end
        @(negedge i_clk);
    endtask

    // Serve any refreshes in the way until a line command is offered.
    task automatic wait_line_cmd(output logic ok);
        logic [1:0] op; logic [8:0] ln; logic [1:0] bk; logic ra, wa, sok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (o_cmd_valid && o_cmd_op != 2'd3) begin ok = 1'b1; break; end
            if (o_cmd_valid) serve(1'b1, op, ln, bk, ra, wa, sok);
            else @(negedge i_clk);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL line_cmd_timeout: no line command within bound");
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        i_wr_line_req = 1'b0; i_wr_line = 9'd0;
        i_rd_line_req = 1'b0; i_rd_line = 9'd0;
        i_wr_frame_end = 1'b0; i_rd_frame_end = 1'b0;
        i_cmd_ready = 1'b0; i_cmd_done = 1'b0;
        repeat (3) @(negedge i_clk);
        total++; if (o_cmd_valid !== 1'b0 || o_busy !== 1'b0) begin bad++;
            $display("FAIL reset_fsm: valid=%b busy=%b want 0 0", o_cmd_valid, o_busy); end
        total++; if (o_cmd_op !== 2'd0 || o_rd_line_ack !== 1'b0 || o_wr_line_ack !== 1'b0) begin bad++;
            $display("FAIL reset_outs: op=%0d rack=%b wack=%b want 0 0 0", o_cmd_op, o_rd_line_ack, o_wr_line_ack); end
        total++; if (o_wr_bank !== 2'd0 || o_rd_bank !== 2'd1) begin bad++;
            $display("FAIL reset_banks: W=%0d R=%0d want 0 1", o_wr_bank, o_rd_bank); end
        total++; if (o_ref_overrun !== 1'b0) begin bad++;
            $display("FAIL reset_overrun: got %b want 0", o_ref_overrun); end
    endtask

    // Timer reaches 15 on the 15th edge after release and wraps on the 16th
    // (pend=1); IDLE grants on the 17th, so valid first shows at negedge 17.
    task automatic test_first_refresh();
        int n;
        logic [1:0] op; logic [8:0] ln; logic [1:0] bk; logic ra, wa, ok;
        i_reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            n++;
            if (o_cmd_valid) break;
        end
        total++; if (n !== 17) begin bad++;
            $display("FAIL first_refresh_time: valid at cycle %0d want 17", n); end
        serve(1'b0, op, ln, bk, ra, wa, ok);
        total++; if (op !== 2'd3 || bk !== 2'd0 || ln !== 9'd0) begin bad++;
            $display("FAIL first_refresh_cmd: op=%0d bank=%0d line=%0d want 3 0 0", op, bk, ln); end
        total++; if (ra !== 1'b0 || wa !== 1'b0) begin bad++;
            $display("FAIL first_refresh_ack: rack=%b wack=%b want 0 0", ra, wa); end
        total++; if (o_busy !== 1'b0 || o_cmd_valid !== 1'b0) begin bad++;
            $display("FAIL first_refresh_idle: busy=%b valid=%b want 0 0", o_busy, o_cmd_valid); end
    endtask

    task automatic test_rd_wr_same_cycle();
        logic [1:0] op; logic [8:0] ln; logic [1:0] bk; logic ra, wa, ok;
        int extra;
        i_rd_line = 9'd5; i_wr_line = 9'd7;
        i_rd_line_req = 1'b1; i_wr_line_req = 1'b1;
        wait_line_cmd(ok);
        serve(1'b0, op, ln, bk, ra, wa, ok);
        total++; if (op !== 2'd2 || ln !== 9'd5 || bk !== 2'd1) begin bad++;
            $display("FAIL both_first: op=%0d line=%0d bank=%0d want 2 5 1", op, ln, bk); end
        total++; if (ra !== 1'b1 || wa !== 1'b0) begin bad++;
            $display("FAIL both_first_ack: rack=%b wack=%b want 1 0", ra, wa); end
        wait_line_cmd(ok);
        serve(1'b0, op, ln, bk, ra, wa, ok);
        total++; if (op !== 2'd1 || ln !== 9'd7 || bk !== 2'd0) begin bad++;
            $display("FAIL both_second: op=%0d line=%0d bank=%0d want 1 7 0", op, ln, bk); end
        total++; if (ra !== 1'b0 || wa !== 1'b1) begin bad++;
            $display("FAIL both_second_ack: rack=%b wack=%b want 0 1", ra, wa); end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_rd_line_ack || o_wr_line_ack) extra++;
            if (o_cmd_valid && o_cmd_op != 2'd3) extra++;
            @(negedge i_clk);
        end
        total++; if (extra !== 0) begin bad++;
            $display("FAIL both_extra: %0d extra acks/line cmds want 0", extra); end
    endtask

    task automatic test_ready_stall();
        logic [1:0] op; logic [8:0] ln; logic [1:0] bk; logic ra, wa, ok;
        int unstable;
        i_wr_line = 9'd9; i_wr_line_req = 1'b1;
        wait_line_cmd(ok);
        total++; if (o_cmd_op !== 2'd1 || o_cmd_line !== 9'd9 || o_cmd_bank !== 2'd0) begin bad++;
            $display("FAIL stall_cmd: op=%0d line=%0d bank=%0d want 1 9 0", o_cmd_op, o_cmd_line, o_cmd_bank); end
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (o_cmd_valid !== 1'b1 || o_cmd_op !== 2'd1 || o_cmd_line !== 9'd9 || o_cmd_bank !== 2'd0)
                unstable++;
        end
        total++; if (unstable !== 0) begin bad++;
            $display("FAIL stall_stable: %0d unstable cycles want 0", unstable); end
        serve(1'b0, op, ln, bk, ra, wa, ok);
        total++; if (wa !== 1'b1 || ln !== 9'd9) begin bad++;
            $display("FAIL stall_ack: wack=%b line=%0d want 1 9", wa, ln); end
    endtask

    task automatic test_refresh_urgency();
        logic [1:0] op; logic [8:0] ln; logic [1:0] bk; logic ra, wa, ok;
        int wrong;
        i_rd_line = 9'd11; i_rd_line_req = 1'b1;
        wait_line_cmd(ok);
        total++; if (o_cmd_op !== 2'd2) begin bad++;
            $display("FAIL urg_read: op=%0d want 2", o_cmd_op); end
        i_cmd_ready = 1'b1;
        @(negedge i_clk);
        i_cmd_ready = 1'b0;
        // 80 cycles of WAIT = 5 refresh ticks, so pend is at least 4.
        wrong = 0;
        for (int i = 0; i < 80; i++) begin
            if (o_busy !== 1'b1 || o_cmd_valid !== 1'b0) wrong++;
            @(negedge i_clk);
        end
        total++; if (wrong !== 0) begin bad++;
            $display("FAIL urg_wait: %0d cycles left WAIT want 0", wrong); end
        i_cmd_done = 1'b1;
        @(negedge i_clk);
        i_cmd_done = 1'b0;
        total++; if (o_rd_line_ack !== 1'b1) begin bad++;
            $display("FAIL urg_read_ack: rack=%b want 1", o_rd_line_ack); end
        @(negedge i_clk);
        serve(1'b1, op, ln, bk, ra, wa, ok);
        total++; if (op !== 2'd3) begin bad++;
            $display("FAIL urg_priority: op=%0d want 3 with read pending", op); end
        wait_line_cmd(ok);
        serve(1'b0, op, ln, bk, ra, wa, ok);
        total++; if (op !== 2'd2 || ln !== 9'd11 || ra !== 1'b1) begin bad++;
            $display("FAIL urg_read_after: op=%0d line=%0d rack=%b want 2 11 1", op, ln, ra); end
    endtask

    task automatic test_bank_rotation();
        logic [1:0] op; logic [8:0] ln; logic [1:0] bk; logic ra, wa, ok;
        i_wr_frame_end = 1'b1; @(negedge i_clk); i_wr_frame_end = 1'b0; @(negedge i_clk);
        total++; if (o_wr_bank !== 2'd2 || o_rd_bank !== 2'd1) begin bad++;
            $display("FAIL rot_wr_end: W=%0d R=%0d want 2 1", o_wr_bank, o_rd_bank); end
        i_rd_frame_end = 1'b1; @(negedge i_clk); i_rd_frame_end = 1'b0; @(negedge i_clk);
        total++; if (o_rd_bank !== 2'd0) begin bad++;
            $display("FAIL rot_rd_end: R=%0d want 0", o_rd_bank); end
        i_rd_frame_end = 1'b1; @(negedge i_clk); i_rd_frame_end = 1'b0; @(negedge i_clk);
        total++; if (o_rd_bank !== 2'd0 || o_wr_bank !== 2'd2) begin bad++;
            $display("FAIL rot_repeat: W=%0d R=%0d want 2 0", o_wr_bank, o_rd_bank); end
        i_wr_frame_end = 1'b1; i_rd_frame_end = 1'b1; @(negedge i_clk);
        i_wr_frame_end = 1'b0; i_rd_frame_end = 1'b0; @(negedge i_clk);
        total++; if (o_wr_bank !== 2'd1 || o_rd_bank !== 2'd2) begin bad++;
            $display("FAIL rot_both: W=%0d R=%0d want 1 2", o_wr_bank, o_rd_bank); end
        // L=2 after the simultaneous pulses with fresh cleared: a lone
        // rd_frame_end must keep R=2.
        i_rd_frame_end = 1'b1; @(negedge i_clk); i_rd_frame_end = 1'b0; @(negedge i_clk);
        total++; if (o_rd_bank !== 2'd2) begin bad++;
            $display("FAIL rot_both_fresh: R=%0d want 2", o_rd_bank); end
        i_rd_line = 9'd4; i_wr_line = 9'd3;
        i_rd_line_req = 1'b1; i_wr_line_req = 1'b1;
        wait_line_cmd(ok);
        serve(1'b0, op, ln, bk, ra, wa, ok);
        total++; if (op !== 2'd2 || bk !== 2'd2 || ln !== 9'd4) begin bad++;
            $display("FAIL rot_read_bank: op=%0d bank=%0d line=%0d want 2 2 4", op, bk, ln); end
        wait_line_cmd(ok);
        serve(1'b0, op, ln, bk, ra, wa, ok);
        total++; if (op !== 2'd1 || bk !== 2'd1 || ln !== 9'd3) begin bad++;
            $display("FAIL rot_write_bank: op=%0d bank=%0d line=%0d want 1 1 3", op, bk, ln); end
    endtask

    task automatic test_reset_mid_wait();
        logic ok;
        int stray;
        i_rd_line = 9'd6; i_rd_line_req = 1'b1;
        wait_line_cmd(ok);
        i_cmd_ready = 1'b1;
        @(negedge i_clk);
        i_cmd_ready = 1'b0;
        total++; if (o_busy !== 1'b1 || o_cmd_valid !== 1'b0) begin bad++;
            $display("FAIL midwait_state: busy=%b valid=%b want 1 0", o_busy, o_cmd_valid); end
        #2 i_reset_n = 1'b0;
        #1;
        total++; if (o_busy !== 1'b0 || o_cmd_valid !== 1'b0 || o_cmd_op !== 2'd0 ||
                     o_rd_line_ack !== 1'b0 || o_wr_line_ack !== 1'b0) begin bad++;
            $display("FAIL midwait_async: busy=%b valid=%b op=%0d rack=%b wack=%b want all 0",
                     o_busy, o_cmd_valid, o_cmd_op, o_rd_line_ack, o_wr_line_ack); end
        total++; if (o_wr_bank !== 2'd0 || o_rd_bank !== 2'd1) begin bad++;
            $display("FAIL midwait_banks: W=%0d R=%0d want 0 1", o_wr_bank, o_rd_bank); end
        i_rd_line_req = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_cmd_done = 1'b1;
        @(negedge i_clk);
        i_cmd_done = 1'b0;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_rd_line_ack || o_wr_line_ack || o_cmd_valid || o_busy) stray++;
            @(negedge i_clk);
        end
        total++; if (stray !== 0) begin bad++;
            $display("FAIL midwait_after: %0d stray cycles want 0", stray); end
    endtask

    initial begin
        test_reset();
        test_first_refresh();
        test_rd_wr_same_cycle();
        test_ready_stall();
        test_refresh_urgency();
        test_bank_rotation();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_line_sched.md
Name: sdram_line_sched

Overview:
- Schedules all SDRAM line traffic for the capture path. It arbitrates between capture line writes (input FIFO to SDRAM), display line reads (SDRAM to line buffer) and periodic auto-refresh.
- It issues one line-level command at a time to the SDRAM command engine using a valid/ready/done handshake.
- It owns triple-buffer frame bank rotation, so the capture side and display side never use the same SDRAM bank.
- It sits in the SDRAM clock domain, between the CDC-synchronised capture/display line requests and the SDRAM controller core.

Parameters:
- REFI_CYCLES, 889, i_clk cycles per refresh tick (7.8 us at 114 MHz).
- REF_POSTPONE, 4, pending-refresh count at which refresh becomes urgent.
- LINE_W, 9, line index width.

Ports:
- i_clk  in  1  SDRAM-domain clock
- i_reset_n  in  1  asynchronous active-low reset
- i_wr_line_req  in  1  capture line ready in FIFO; level, held until o_wr_line_ack
- i_wr_line  in  LINE_W  capture line index
- o_wr_line_ack  out  1  1-cycle pulse: write line completed
- i_rd_line_req  in  1  display line fetch request; level, held until o_rd_line_ack
- i_rd_line  in  LINE_W  display line index
- o_rd_line_ack  out  1  1-cycle pulse: read line completed
- i_wr_frame_end  in  1  1-cycle pulse: capture frame finished
- i_rd_frame_end  in  1  1-cycle pulse: display frame finished
- o_cmd_valid  out  1  command offered to the SDRAM engine
- o_cmd_op  out  2  command op: 0 NOP, 1 WRITE_LINE, 2 READ_LINE, 3 REFRESH
- o_cmd_line  out  LINE_W  line index for the command
- o_cmd_bank  out  2  SDRAM bank (BS) for the command
- i_cmd_ready  in  1  engine accepts the command this cycle
- i_cmd_done  in  1  1-cycle pulse: engine finished the command
- o_wr_bank  out  2  current capture bank
- o_rd_bank  out  2  current display bank
- o_ref_overrun  out  1  sticky: the pending-refresh counter saturated
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, any time, including mid-command):
  - FSM goes to IDLE; all command outputs and acks go to 0; o_busy=0.
  - Refresh tick counter=0, pend=0, o_ref_overrun=0.
  - Banks: W=0, R=1, L=1; fresh=0.
- Refresh timer:
  - Counter counts 0..REFI_CYCLES-1 and wraps.
  - On wrap, pend increments, saturating at 7. A wrap while pend=7 sets o_ref_overrun.
  - pend decrements on the acceptance cycle of a REFRESH command (o_cmd_valid & i_cmd_ready).
  - Wrap and decrement in the same cycle leave pend unchanged.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE arbitration, fixed priority:
  1. REFRESH if pend>=REF_POSTPONE.
  2. READ_LINE if i_rd_line_req.
  3. WRITE_LINE if i_wr_line_req.
  4. REFRESH if pend>0.
  5. Otherwise stay in IDLE.
- Grant latching: on grant, latch op, line (i_rd_line/i_wr_line; 0 for refresh) and bank (R for read, W for write, 0 for refresh), then go to ISSUE next cycle.
- ISSUE: o_cmd_valid=1 with stable op/line/bank until i_cmd_ready=1, then go to WAIT with o_cmd_valid=0 the next cycle.
- WAIT: on i_cmd_done go to DONE. An i_cmd_done arriving in any other state is ignored.
- DONE: hold one cycle.
  - Pulse o_rd_line_ack or o_wr_line_ack for a line op; no ack for refresh.
  - Next state is IDLE.
  - A requester drops its req on the cycle after the ack, so IDLE never re-grants a completed line.
- Minimum turnaround is 4 cycles per command (IDLE, ISSUE, WAIT, DONE) when i_cmd_ready and i_cmd_done both come at the earliest possible cycle.
- Bank rotation (triple buffer; W≠R invariant; banks 0..2; bank 3 unused):
  - i_wr_frame_end: L<=W; fresh<=1; W<=the single bank in {0,1,2} not equal to old W or old R.
  - i_rd_frame_end: if fresh, R<=L and fresh<=0; otherwise R is unchanged and the display repeats its frame.
  - Both pulses in the same cycle: apply the write rule first, then the read rule on the updated L. Result: R<=old W, L<=old W, W<=the bank not in {old W, old R}, fresh<=0.
  - A command already in flight keeps its latched bank.
- o_wr_bank/o_rd_bank are registered copies of W/R.

Decomposition:
- sdram_sched_pkg holds:
  - op encodings CMD_NOP/CMD_WRITE/CMD_READ/CMD_REFRESH;
  - FSM state encodings;
  - bank count constant NUM_FB=3.
- One sub-module, fb_bank_rotator: W/R/L/fresh registers and their update rules. The FSM, arbiter and refresh timer stay in the top.

Test Plan:
- Reset release with REFI_CYCLES=16: after 16 cycles, one REFRESH is issued (op=3, bank=0). With ready and done immediate, pend returns to 0 and there is no ack pulse.
- i_rd_line_req and i_wr_line_req raised in the same cycle (rd_line=5, wr_line=7), pend=0:
  - READ_LINE line 5 bank 1 is issued first, then o_rd_line_ack;
  - then WRITE_LINE line 7 bank 0, then o_wr_line_ack;
  - exactly one ack per request.
- i_cmd_ready held 0 for 10 cycles: o_cmd_valid, op, line and bank stay stable all 10 cycles, and nothing else is issued.
- Refresh urgency: i_rd_line_req held continuously while i_cmd_done is delayed until pend reaches 4. The next grant is REFRESH, ahead of the pending read.
- Bank rotation:
  - wr_frame_end gives W=2, L=0.
  - rd_frame_end gives R=0.
  - A second rd_frame_end leaves R=0 (not fresh).
  - Simultaneous pulses from W=2, R=0 give R=2, L=2, W=1.
- Reset asserted mid-WAIT: all outputs are 0 immediately (async), banks return to W=0/R=1, and no ack is emitted after release.
